// File: rtl/row_window_pkg.sv
// -----------------------------------------------------------------------------
// row_window_pkg
// Shared definitions for the row-window buffer that feeds the 8-tap
// interpolation filter array:
//   - MODE_SLIDE / MODE_BLOCK encodings of the 'mode' input
//   - default geometry (pixel width, pixels per row, rows per window,
//     window-counter width)
//   - win_width(): flat width of one DEPTH-row window in bits
// -----------------------------------------------------------------------------
package row_window_pkg;

    localparam logic MODE_SLIDE = 1'b0;  // overlapping windows, one per row
    localparam logic MODE_BLOCK = 1'b1;  // non-overlapping windows

    localparam int DEF_PIX_W   = 8;
    localparam int DEF_ROW_PIX = 8;
    localparam int DEF_DEPTH   = 15;     // block rows + filter taps - 1
    localparam int DEF_CNT_W   = 16;

    function automatic int win_width(input int pix_w, input int row_pix, input int depth);
        return pix_w * row_pix * depth;
    endfunction

endpackage

// File: rtl/row_window_transpose.sv
// -----------------------------------------------------------------------------
// row_window_transpose
// Purely combinational index remap of a window from row-major to
// column-major order, so each pixel column is a contiguous vertical lane.
//   row_major : row r, column c at bits [(r*ROW_PIX + c)*PIX_W +: PIX_W]
//   col_major : row r, column c at bits [(c*DEPTH  + r)*PIX_W +: PIX_W]
// Only instantiated when ROW_WINDOW_TRANSPOSE_EN is defined.
// -----------------------------------------------------------------------------
module row_window_transpose
    import row_window_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int ROW_PIX = DEF_ROW_PIX,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic [win_width(PIX_W, ROW_PIX, DEPTH)-1:0] row_major,
    output logic [win_width(PIX_W, ROW_PIX, DEPTH)-1:0] col_major
);

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        for (genvar c = 0; c < ROW_PIX; c++) begin : g_col
            assign col_major[(c*DEPTH + r)*PIX_W +: PIX_W] =
                   row_major[(r*ROW_PIX + c)*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/row_window_buffer.sv
// -----------------------------------------------------------------------------
// row_window_buffer
// Holds the last DEPTH input rows and presents them as one window to the
// downstream filter stage, with valid/ready flow control on both sides.
//
// Ports
//   clock, reset_L : rising-edge clock, asynchronous active-low reset
//   clear          : synchronous flush of fill/valid/window count (storage kept)
//   mode           : MODE_SLIDE / MODE_BLOCK, sampled at each window hand-off
//   in_valid/in_ready/in_row     : row input, pixel 0 in LSBs
//   out_valid/out_ready/out_win  : window output, row 0 (oldest) in LSBs
//   fill_cnt       : rows currently held, saturating at DEPTH
//   win_cnt        : windows handed off since reset/clear, wraps
//
// Build option
//   ROW_WINDOW_TRANSPOSE_EN : out_win is column-major (one lane of DEPTH
//                             pixels per column); same latency.
// -----------------------------------------------------------------------------
module row_window_buffer
    import row_window_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int ROW_PIX = DEF_ROW_PIX,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                                        clock,
    input  logic                                        reset_L,
    input  logic                                        clear,
    input  logic                                        mode,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [ROW_PIX*PIX_W-1:0]                    in_row,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [win_width(PIX_W, ROW_PIX, DEPTH)-1:0] out_win,
    output logic [$clog2(DEPTH+1)-1:0]                  fill_cnt,
    output logic [CNT_W-1:0]                            win_cnt
);

    localparam int ROW_W  = ROW_PIX * PIX_W;
    localparam int WIN_W  = win_width(PIX_W, ROW_PIX, DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    logic [WIN_W-1:0]  store_q;    // row r at bits [r*ROW_W +: ROW_W]
    logic [WIN_W-1:0]  store_nxt;
    logic [WIN_W-1:0]  win_map;    // store_nxt in output layout
    logic [FILL_W-1:0] fill_inc;
    logic [FILL_W-1:0] fill_nxt;
    logic              in_acc;
    logic              out_acc;
    logic              new_win;

    // A pending window can only be displaced when it is taken this cycle.
    assign in_ready = !out_valid || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    // Shift toward row 0: the oldest row falls out, the new row enters on top.
    assign store_nxt = {in_row, store_q[WIN_W-1 -: WIN_W-ROW_W]};

`ifdef ROW_WINDOW_TRANSPOSE_EN
    row_window_transpose #(
        .PIX_W   (PIX_W),
        .ROW_PIX (ROW_PIX),
        .DEPTH   (DEPTH)
    ) u_transpose (
        .row_major (store_nxt),
        .col_major (win_map)
    );
`else
    assign win_map = store_nxt;
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch.
    always_comb begin
        fill_inc = (fill_cnt == FULL) ? FULL : fill_cnt + 1'b1;
        fill_nxt = fill_cnt;
        if (out_acc && (mode == MODE_BLOCK)) begin
            // Block hand-off starts a fresh block; a coincident row is its first.
            fill_nxt = in_acc ? FILL_W'(1) : '0;
        end else if (in_acc) begin
            fill_nxt = fill_inc;
        end
        new_win = in_acc && (fill_nxt == FULL);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            // NOTE: row storage is explicitly zeroed so a reset never exposes stale rows.
            store_q   <= '0;
            out_win   <= '0;
            fill_cnt  <= '0;
            win_cnt   <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            // Flush bookkeeping only; the row presented this cycle is dropped.
            fill_cnt  <= '0;
            win_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_acc) begin
                store_q <= store_nxt;
                out_win <= win_map;
            end
            fill_cnt <= fill_nxt;
            if (out_acc) begin
                win_cnt <= win_cnt + 1'b1;
            end
            if (new_win) begin
                out_valid <= 1'b1;
            end else if (out_acc) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_row_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_row_window_buffer
// Directed bench for row_window_buffer: reset, SLIDE fill and streaming,
// backpressure, clear collision, BLOCK mode, mode change at hand-off,
// asynchronous reset mid-fill and the output pixel layout (row- or
// column-major depending on ROW_WINDOW_TRANSPOSE_EN).
// -----------------------------------------------------------------------------
module tb_row_window_buffer;

    localparam int PIX_W   = 8;
    localparam int ROW_PIX = 8;
    localparam int DEPTH   = 15;
    localparam int CNT_W   = 16;
    localparam int ROW_W   = ROW_PIX * PIX_W;
    localparam int WIN_W   = DEPTH * ROW_W;

    logic             clock = 1'b0;
    logic             reset_L;
    logic             clear;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic             out_valid;
    logic             out_ready;
    logic [WIN_W-1:0] out_win;
    logic [3:0]       fill_cnt;
    logic [CNT_W-1:0] win_cnt;

    int checks = 0;
    int errors = 0;

    row_window_buffer #(
        .PIX_W   (PIX_W),
        .ROW_PIX (ROW_PIX),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .fill_cnt  (fill_cnt),
        .win_cnt   (win_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte position of pixel (row r, column c) inside out_win.
    function automatic int pix_idx(input int r, input int c);
`ifdef ROW_WINDOW_TRANSPOSE_EN
        return c * DEPTH + r;
`else
        return r * ROW_PIX + c;
`endif
    endfunction

    function automatic logic [ROW_W-1:0] urow(input int k);
        return {ROW_PIX{8'(k)}};
    endfunction

    // Window of uniform rows whose values are base, base+1, ... from row 0.
    function automatic logic [WIN_W-1:0] exp_win(input int base);
        logic [WIN_W-1:0] w = '0;
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < ROW_PIX; c++)
                w[pix_idx(r, c)*8 +: 8] = 8'(base + r);
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int k, input logic ordy);
        in_valid  = 1'b1;
        in_row    = urow(k);
        out_ready = ordy;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [ROW_W-1:0] prow;
    logic [WIN_W-1:0] pwin;
    logic [7:0]       byte1;

    initial begin
        reset_L = 1'b0; clear = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_fill", fill_cnt, 0);
        check("rst_win_cnt", win_cnt, 0);
        check("rst_out_win", out_win, 0);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // SLIDE fill with out_ready held high
        for (int k = 1; k <= 14; k++) send(k, 1'b1);
        check("slide_fill14_valid", out_valid, 0);
        check("slide_fill14_cnt", fill_cnt, 14);
        send(15, 1'b1);
        check("slide_w1_valid", out_valid, 1);
        check("slide_w1_fill", fill_cnt, 15);
        check("slide_w1_win", out_win, exp_win(1));
        check("slide_w1_cnt", win_cnt, 0);
        send(16, 1'b1);
        check("slide_w2_valid", out_valid, 1);
        check("slide_w2_win", out_win, exp_win(2));
        check("slide_w2_cnt", win_cnt, 1);
        out_ready = 1'b1;
        tick();
        check("slide_drain_valid", out_valid, 0);
        check("slide_drain_cnt", win_cnt, 2);

        // Backpressure
        send(17, 1'b0);
        check("bp_w3_valid", out_valid, 1);
        check("bp_w3_win", out_win, exp_win(3));
        in_valid = 1'b1; in_row = urow(18); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready_low", in_ready, 0);
            tick();
            check("bp_win_stable", out_win, exp_win(3));
            check("bp_fill_full", fill_cnt, 15);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_release_win", out_win, exp_win(4));
        check("bp_release_valid", out_valid, 1);
        check("bp_release_cnt", win_cnt, 3);
        tick();
        check("bp_drain_cnt", win_cnt, 4);
        check("bp_drain_valid", out_valid, 0);

        // clear colliding with in_acc and out_acc
        send(19, 1'b0);
        check("clr_pre_valid", out_valid, 1);
        clear = 1'b1; in_valid = 1'b1; in_row = urow(8'h55); out_ready = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_fill", fill_cnt, 0);
        check("clr_valid", out_valid, 0);
        check("clr_win_cnt", win_cnt, 0);
        check("clr_win_hold", out_win, exp_win(5));
        send(20, 1'b1);
        check("clr_row_dropped", out_win, exp_win(6));
        check("clr_refill_cnt", fill_cnt, 1);

        // BLOCK mode
        pulse_clear();
        mode = 1'b1;
        for (int k = 1; k <= 14; k++) send(k, 1'b1);
        send(15, 1'b1);
        check("blk_w1_valid", out_valid, 1);
        check("blk_w1_win", out_win, exp_win(1));
        send(16, 1'b1);
        check("blk_handoff_fill", fill_cnt, 1);
        check("blk_handoff_valid", out_valid, 0);
        check("blk_handoff_cnt", win_cnt, 1);
        for (int k = 17; k <= 29; k++) send(k, 1'b1);
        check("blk_fill14_valid", out_valid, 0);
        check("blk_fill14_cnt", fill_cnt, 14);
        send(30, 1'b1);
        check("blk_w2_valid", out_valid, 1);
        check("blk_w2_win", out_win, exp_win(16));
        send(31, 1'b1);
        check("blk_end_fill", fill_cnt, 1);
        check("blk_end_cnt", win_cnt, 2);
        check("blk_end_valid", out_valid, 0);

        // Mode switched to SLIDE mid-fill applies at the next hand-off
        mode = 1'b0;
        for (int k = 32; k <= 45; k++) send(k, 1'b1);
        check("mode_w_valid", out_valid, 1);
        check("mode_w_win", out_win, exp_win(31));
        send(46, 1'b1);
        check("mode_slide_valid", out_valid, 1);
        check("mode_slide_fill", fill_cnt, 15);
        check("mode_slide_cnt", win_cnt, 3);

        // Asynchronous reset mid-stream, applied between edges
        for (int k = 1; k <= 7; k++) send(k, 1'b1);
        check("pre_rst_cnt", win_cnt, 10);
        #3;
        reset_L = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_fill", fill_cnt, 0);
        check("arst_win_cnt", win_cnt, 0);
        check("arst_out_win", out_win, 0);
        #2;
        reset_L = 1'b1;
        for (int k = 1; k <= 14; k++) send(k, 1'b1);
        check("arst_fill14_valid", out_valid, 0);
        check("arst_fill14_cnt", fill_cnt, 14);
        send(15, 1'b1);
        check("arst_w_valid", out_valid, 1);
        check("arst_w_win", out_win, exp_win(1));

        // Pixel layout: pixel (r, c) = r*16 + c
        pulse_clear();
        pwin = '0;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < ROW_PIX; c++) begin
                prow[c*8 +: 8] = 8'(r*16 + c);
                pwin[pix_idx(r, c)*8 +: 8] = 8'(r*16 + c);
            end
            in_valid = 1'b1; in_row = prow; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        check("layout_valid", out_valid, 1);
        check("layout_win", out_win, pwin);
        byte1 = out_win[15:8];
`ifdef ROW_WINDOW_TRANSPOSE_EN
        check("layout_byte1", byte1, 8'h10);
`else
        check("layout_byte1", byte1, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
